// File: rtl/parking_pkg.sv
// Shared types and default sizing for the parking gate controller.
package parking_pkg;

   typedef enum logic {
      CLOSED = 1'b0,
      OPEN   = 1'b1
   } gate_state_t;

   localparam int unsigned CAPACITY_DEF     = 32;
   localparam int unsigned OPEN_TIMEOUT_DEF = 20;
   localparam int unsigned OCC_W            = 6;

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Barrier control bundle: request/sensor inputs and gate/occupancy status outputs.
interface parking_gate_ctrl_if;
   import parking_pkg::*;

   logic             entry_grant;
   logic             entry_sensor;
   logic             exit_request;
   logic             exit_sensor;
   logic             alarm_clr;
   logic             gate_in_open;
   logic             gate_out_open;
   logic [OCC_W-1:0] occupancy;
   logic             full;
   logic             empty;
   logic             denied;
   logic             alarm;

   modport master (
      output entry_grant, entry_sensor, exit_request, exit_sensor, alarm_clr,
      input  gate_in_open, gate_out_open, occupancy, full, empty, denied, alarm
   );

   modport slave (
      input  entry_grant, entry_sensor, exit_request, exit_sensor, alarm_clr,
      output gate_in_open, gate_out_open, occupancy, full, empty, denied, alarm
   );

endinterface

// File: rtl/gate_channel.sv
// One barrier: CLOSED/OPEN state plus an open-time timer that auto-closes the gate.
module gate_channel
   import parking_pkg::*;
#(
   parameter int unsigned TIMEOUT = OPEN_TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic open_req,
   input  logic sensor,
   output logic open,
   output logic crossed,
   output logic timed_out,
   output logic tailgate
);

   localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   gate_state_t   state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          at_limit;

   assign open = (state_q == OPEN);

   // A crossing takes precedence over an expiring timer in the same cycle.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      crossed   = 1'b0;
      timed_out = 1'b0;
      tailgate  = 1'b0;
      at_limit  = (timer_q == TW'(TIMEOUT - 1));
      case (state_q)
         CLOSED: begin
            tailgate = sensor;
            if (open_req) begin
               state_d = OPEN;
               timer_d = '0;
            end
         end
         OPEN: begin
            if (sensor) begin
               crossed = 1'b1;
               state_d = CLOSED;
            end else if (at_limit) begin
               timed_out = 1'b1;
               state_d   = CLOSED;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = CLOSED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLOSED;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking lot controller: entry/exit barriers, saturating occupancy count, deny pulse, sticky alarm.
module parking_gate_ctrl
   import parking_pkg::*;
#(
   parameter int unsigned CAPACITY     = CAPACITY_DEF,
   parameter int unsigned OPEN_TIMEOUT = OPEN_TIMEOUT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   parking_gate_ctrl_if.slave  bus
);

   logic             grant_q, grant_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             denied_q, denied_d;
   logic             alarm_q, alarm_d;
   logic             alarm_set;

   logic full, empty, grant_rise;
   logic in_open, in_crossed, in_timed_out, in_tailgate;
   logic out_open, out_crossed, out_timed_out, out_tailgate;
   logic unused_timeouts;

   assign full       = (occ_q == OCC_W'(CAPACITY));
   assign empty      = (occ_q == '0);
   assign grant_rise = bus.entry_grant & ~grant_q;

   gate_channel #(.TIMEOUT(OPEN_TIMEOUT)) u_entry (
      .clk       (clk),
      .rst       (rst),
      .open_req  (grant_rise & ~full),
      .sensor    (bus.entry_sensor),
      .open      (in_open),
      .crossed   (in_crossed),
      .timed_out (in_timed_out),
      .tailgate  (in_tailgate)
   );

   gate_channel #(.TIMEOUT(OPEN_TIMEOUT)) u_exit (
      .clk       (clk),
      .rst       (rst),
      .open_req  (bus.exit_request & ~empty),
      .sensor    (bus.exit_sensor),
      .open      (out_open),
      .crossed   (out_crossed),
      .timed_out (out_timed_out),
      .tailgate  (out_tailgate)
   );

   // Timeouts close the gate silently; nothing at this level reacts to them.
   assign unused_timeouts = in_timed_out | out_timed_out;

   // Simultaneous in/out crossings cancel; a lone crossing past a bound raises alarm instead.
   always_comb begin
      grant_d   = bus.entry_grant;
      denied_d  = grant_rise & full;
      occ_d     = occ_q;
      alarm_set = in_tailgate | out_tailgate;
      if (in_crossed && !out_crossed) begin
         if (full) alarm_set = 1'b1;
         else      occ_d     = occ_q + OCC_W'(1);
      end else if (out_crossed && !in_crossed) begin
         if (empty) alarm_set = 1'b1;
         else       occ_d     = occ_q - OCC_W'(1);
      end
      alarm_d = (alarm_q & ~bus.alarm_clr) | alarm_set;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_q  <= 1'b0;
         occ_q    <= '0;
         denied_q <= 1'b0;
         alarm_q  <= 1'b0;
      end else begin
         grant_q  <= grant_d;
         occ_q    <= occ_d;
         denied_q <= denied_d;
         alarm_q  <= alarm_d;
      end
   end

   assign bus.gate_in_open  = in_open;
   assign bus.gate_out_open = out_open;
   assign bus.occupancy     = occ_q;
   assign bus.full          = full;
   assign bus.empty         = empty;
   assign bus.denied        = denied_q;
   assign bus.alarm         = alarm_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed vector table, corner sequences, random traffic vs. a lot model.
module tb_parking_gate_ctrl;
   import parking_pkg::*;

   localparam int CAP = 32;
   localparam int TO  = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   parking_gate_ctrl_if bus();

   parking_gate_ctrl #(.CAPACITY(CAP), .OPEN_TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Lot model: each gate open flag with cycles of open time remaining.
   bit m_in_open, m_out_open, m_alarm, m_denied, m_prev_grant;
   int m_in_left, m_out_left, m_occ;

   typedef struct {
      bit r, g, es, xr, xs, clr;
      bit e_in, e_out;
      int e_occ;
      bit e_alarm, e_den;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_step(input bit r, g, es, xr, xs, clr);
      bit rise, full_now, empty_now, set;
      int delta;
      if (r) begin
         m_in_open = 0; m_out_open = 0; m_in_left = 0; m_out_left = 0;
         m_occ = 0; m_alarm = 0; m_denied = 0; m_prev_grant = 0;
         return;
      end
      rise      = g && !m_prev_grant;
      m_prev_grant = g;
      full_now  = (m_occ == CAP);
      empty_now = (m_occ == 0);
      set   = 0;
      delta = 0;
      if (m_in_open) begin
         if (es) begin delta++; m_in_open = 0; end
         else if (m_in_left == 1) m_in_open = 0;
         else m_in_left--;
      end else begin
         if (es) set = 1;
         if (rise && !full_now) begin m_in_open = 1; m_in_left = TO; end
      end
      if (m_out_open) begin
         if (xs) begin delta--; m_out_open = 0; end
         else if (m_out_left == 1) m_out_open = 0;
         else m_out_left--;
      end else begin
         if (xs) set = 1;
         if (xr && !empty_now) begin m_out_open = 1; m_out_left = TO; end
      end
      if (m_occ + delta > CAP || m_occ + delta < 0) set = 1;
      else m_occ += delta;
      m_denied = rise && full_now;
      m_alarm  = (m_alarm && !clr) || set;
   endtask

   task automatic check_model();
      check("m_in_open",  32'(bus.gate_in_open),  32'(m_in_open));
      check("m_out_open", 32'(bus.gate_out_open), 32'(m_out_open));
      check("m_occ",      32'(bus.occupancy),     m_occ);
      check("m_full",     32'(bus.full),          32'(m_occ == CAP));
      check("m_empty",    32'(bus.empty),         32'(m_occ == 0));
      check("m_denied",   32'(bus.denied),        32'(m_denied));
      check("m_alarm",    32'(bus.alarm),         32'(m_alarm));
   endtask

   task automatic step(input bit r, g, es, xr, xs, clr);
      @(negedge clk);
      rst              = r;
      bus.entry_grant  = g;
      bus.entry_sensor = es;
      bus.exit_request = xr;
      bus.exit_sensor  = xs;
      bus.alarm_clr    = clr;
      model_step(r, g, es, xr, xs, clr);
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic add_cars(input int n);
      for (int k = 0; k < n; k++) begin
         step(0, 1, 0, 0, 0, 0);
         step(0, 0, 1, 0, 0, 0);
      end
   endtask

   initial begin
      int cnt;
      bus.entry_grant  = 0;
      bus.entry_sensor = 0;
      bus.exit_request = 0;
      bus.exit_sensor  = 0;
      bus.alarm_clr    = 0;

      //            r  g es xr xs clr  in out occ al den
      vecs[0]  = '{1, 0, 0, 0, 0, 0,   0, 0,  0, 0, 0};
      vecs[1]  = '{0, 1, 0, 0, 0, 0,   1, 0,  0, 0, 0};
      vecs[2]  = '{0, 1, 0, 0, 0, 0,   1, 0,  0, 0, 0};
      vecs[3]  = '{0, 0, 0, 0, 0, 0,   1, 0,  0, 0, 0};
      vecs[4]  = '{0, 0, 1, 0, 0, 0,   0, 0,  1, 0, 0};
      vecs[5]  = '{0, 0, 0, 0, 0, 0,   0, 0,  1, 0, 0};
      vecs[6]  = '{0, 0, 0, 0, 1, 0,   0, 0,  1, 1, 0};
      vecs[7]  = '{0, 0, 0, 0, 0, 0,   0, 0,  1, 1, 0};
      vecs[8]  = '{0, 0, 0, 0, 1, 1,   0, 0,  1, 1, 0};
      vecs[9]  = '{0, 0, 0, 0, 0, 1,   0, 0,  1, 0, 0};
      vecs[10] = '{0, 0, 0, 1, 0, 0,   0, 1,  1, 0, 0};
      vecs[11] = '{0, 0, 0, 0, 1, 0,   0, 0,  0, 0, 0};
      vecs[12] = '{0, 0, 0, 1, 0, 0,   0, 0,  0, 0, 0};
      vecs[13] = '{0, 1, 0, 0, 0, 0,   1, 0,  0, 0, 0};
      vecs[14] = '{1, 1, 0, 0, 0, 0,   0, 0,  0, 0, 0};
      vecs[15] = '{0, 1, 0, 0, 0, 0,   1, 0,  0, 0, 0};
      vecs[16] = '{0, 0, 0, 0, 0, 0,   1, 0,  0, 0, 0};
      vecs[17] = '{0, 0, 1, 0, 0, 0,   0, 0,  1, 0, 0};

      for (int i = 0; i < 18; i++) begin
         step(vecs[i].r, vecs[i].g, vecs[i].es, vecs[i].xr, vecs[i].xs, vecs[i].clr);
         check($sformatf("vec%0d_in", i),     32'(bus.gate_in_open),  32'(vecs[i].e_in));
         check($sformatf("vec%0d_out", i),    32'(bus.gate_out_open), 32'(vecs[i].e_out));
         check($sformatf("vec%0d_occ", i),    32'(bus.occupancy),     vecs[i].e_occ);
         check($sformatf("vec%0d_alarm", i),  32'(bus.alarm),         32'(vecs[i].e_alarm));
         check($sformatf("vec%0d_denied", i), 32'(bus.denied),        32'(vecs[i].e_den));
      end

      // Unanswered grant held high: open for exactly the timeout, never re-opened.
      step(1, 0, 0, 0, 0, 0);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step(0, 1, 0, 0, 0, 0);
         cnt += 32'(bus.gate_in_open);
      end
      check("timeout_open_cycles", cnt, TO);
      check("timeout_occ", 32'(bus.occupancy), 0);
      check("timeout_alarm", 32'(bus.alarm), 0);

      // Fill the lot, then a refused grant.
      step(1, 0, 0, 0, 0, 0);
      add_cars(CAP);
      check("fill_occ", 32'(bus.occupancy), CAP);
      check("fill_full", 32'(bus.full), 1);
      step(0, 1, 0, 0, 0, 0);
      check("deny_pulse", 32'(bus.denied), 1);
      check("deny_gate_closed", 32'(bus.gate_in_open), 0);
      step(0, 0, 0, 0, 0, 0);
      check("deny_pulse_end", 32'(bus.denied), 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      check("leave_full_occ", 32'(bus.occupancy), CAP - 1);
      check("leave_full_flag", 32'(bus.full), 0);

      // Simultaneous entry and exit crossing.
      step(1, 0, 0, 0, 0, 0);
      add_cars(5);
      step(0, 1, 0, 1, 0, 0);
      check("both_open_in", 32'(bus.gate_in_open), 1);
      check("both_open_out", 32'(bus.gate_out_open), 1);
      step(0, 0, 1, 0, 1, 0);
      check("both_cross_occ", 32'(bus.occupancy), 5);
      check("both_cross_in", 32'(bus.gate_in_open), 0);
      check("both_cross_out", 32'(bus.gate_out_open), 0);

      // Reset while the entry gate is open.
      step(0, 1, 0, 0, 0, 0);
      check("pre_rst_open", 32'(bus.gate_in_open), 1);
      step(1, 0, 1, 0, 0, 0);
      check("rst_gate", 32'(bus.gate_in_open), 0);
      check("rst_occ", 32'(bus.occupancy), 0);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 6) == 0,
              $urandom_range(0, 15) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/parking_gate_ctrl.md
PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 Parameter CAPACITY, default 32: number of parking slots, range 1..63.
REQ-002 Parameter OPEN_TIMEOUT, default 20: clock cycles a gate stays open without a crossing.
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port entry_grant, input, 1: high while the upstream password controller shows its green LED.
REQ-006 Port entry_sensor, input, 1: entry barrier beam broken (car crossed in).
REQ-007 Port exit_request, input, 1: car waiting at exit barrier.
REQ-008 Port exit_sensor, input, 1: exit barrier beam broken (car crossed out).
REQ-009 Port alarm_clr, input, 1: clears the sticky alarm.
REQ-010 Port gate_in_open, output, 1: entry barrier open command.
REQ-011 Port gate_out_open, output, 1: exit barrier open command.
REQ-012 Port occupancy, output, 6: cars currently parked.
REQ-013 Port full / empty, output, 1 each: occupancy==CAPACITY / occupancy==0.
REQ-014 Port denied, output, 1: one-cycle pulse when an entry grant is refused.
REQ-015 Port alarm, output, 1: sticky unauthorised-crossing flag.

Function
REQ-016 Each gate is a 2-state FSM: CLOSED, OPEN. Outputs are registered; gate_*_open = (state==OPEN).
REQ-017 Entry gate: CLOSED->OPEN on the rising edge of entry_grant (prev 0, current 1) when full==0; gate_in_open is high the following cycle.
REQ-018 Rising edge of entry_grant while full==1: gate stays CLOSED; denied pulses high for exactly one cycle.
REQ-019 Exit gate: CLOSED->OPEN when exit_request==1 and empty==0; exit_request while empty is ignored, with no pulse.
REQ-020 OPEN->CLOSED on the gate's sensor==1 (crossing); occupancy +1 (entry) or -1 (exit) in the same edge.
REQ-021 OPEN->CLOSED when the per-gate timer reaches OPEN_TIMEOUT-1 without a crossing; occupancy unchanged.
REQ-022 The timer clears on entering OPEN and counts +1 per cycle in OPEN. A sensor and timeout in the same cycle count as a crossing.
REQ-023 Simultaneous entry and exit crossing: occupancy net unchanged; both gates close.
REQ-024 Occupancy saturates: never exceeds CAPACITY and never goes below 0. A crossing that would overflow or underflow closes the gate, leaves occupancy unchanged and sets alarm.
REQ-025 full and empty are combinational decodes of the registered occupancy.
REQ-026 A sensor high while its gate is CLOSED (tailgating) sets alarm; occupancy unchanged.
REQ-027 alarm stays set until alarm_clr==1. A set and clear in the same cycle leave alarm set.
REQ-028 entry_grant held high re-opens nothing; only a new rising edge re-arms the entry gate.

Reset
REQ-029 On rst==1 at a clock edge: both FSMs CLOSED, timers 0, occupancy 0, denied 0, alarm 0, and the entry_grant edge-detect register 0.
REQ-030 Reset mid-operation (gate OPEN) closes the gate the next cycle and discards pending crossings; rst has priority over all inputs.

Structure
REQ-031 Package parking_pkg holds the gate_state_t enum (CLOSED, OPEN), the CAPACITY and OPEN_TIMEOUT defaults, and the occupancy width constant (6).
REQ-032 Sub-module gate_channel (FSM + timeout timer; outputs open, crossed, timed_out, tailgate) is instantiated twice; the occupancy counter, alarm and denied logic stay in the top level.

Verification
REQ-033 Reset, entry_grant 0->1, entry_sensor pulse 3 cycles later -> gate_in_open high cycles 1..3, occupancy 0->1, gate closes.
REQ-034 Entry_grant rising edge, no sensor -> gate_in_open high exactly 20 cycles, occupancy stays 0, alarm 0.
REQ-035 Fill to 32 cars, then entry_grant edge -> full=1, denied one-cycle pulse, gate_in_open stays 0.
REQ-036 Occupancy 5, both gates open, entry_sensor and exit_sensor in the same cycle -> occupancy 5, both gates closed.
REQ-037 exit_sensor with exit gate CLOSED -> alarm=1 persists; alarm_clr pulse -> alarm=0; exit_request at occupancy 0 -> gate_out_open stays 0.
REQ-038 rst asserted while gate_in_open=1 -> next cycle gate_in_open=0, occupancy=0.
